// File: rtl/ad_ip_jesd204_tpl_adc_sync_capture_if.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_sync_capture_if
// Sample-stream bundle around the TPL ADC capture controller.
//   in_valid / in_data   : formatted link beats entering the controller
//   adc_valid / adc_data : per-channel valid and aligned data towards the DMA
// Channel i occupies in_data/adc_data[W*i +: W], W = DATA_PATH_WIDTH *
// DMA_BITS_PER_SAMPLE.
//   master : the producer of in_* and consumer of adc_* (deframer side)
//   slave  : the capture controller itself
// ---------------------------------------------------------------------------
interface ad_ip_jesd204_tpl_adc_sync_capture_if #(
    parameter int NUM_CHANNELS        = 4,
    parameter int DATA_PATH_WIDTH     = 2,
    parameter int DMA_BITS_PER_SAMPLE = 16
);
    localparam int DW = NUM_CHANNELS * DATA_PATH_WIDTH * DMA_BITS_PER_SAMPLE;

    logic                    in_valid;
    logic [DW-1:0]           in_data;
    logic [NUM_CHANNELS-1:0] adc_valid;
    logic [DW-1:0]           adc_data;

    modport master (
        output in_valid,
        output in_data,
        input  adc_valid,
        input  adc_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output adc_valid,
        output adc_data
    );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_sync_capture.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_sync_capture
// Capture controller between the TPL ADC formatter and the DMA. Link valid
// and formatted data are delayed by LINK_DELAY registers, then per-channel
// valid is gated by an external-sync state machine
// (DISARMED / ARMED / CAPTURING / DONE) which also implements a one-shot,
// length-limited capture with a done pulse and a beat counter.
// Ports:
//   clk, rst          : core clock, asynchronous active-high reset
//   bus (slave)       : in_valid/in_data in, adc_valid/adc_data out
//   ch_enable         : per-channel enable (disabled channels read as zero)
//   ext_sync_arm      : arm request pulse
//   ext_sync_disarm   : disarm request pulse (wins over arm)
//   sync_in           : external trigger level, rising edge triggers
//   sync_manual_req   : software trigger pulse
//   capture_mode      : 0 continuous after trigger, 1 one-shot
//   capture_length    : beats per one-shot, 0 = unlimited
//   adc_sync_status   : high while ARMED (adc_rst_sync mirrors it)
//   capture_active    : high while CAPTURING
//   capture_done      : one-cycle pulse when a one-shot completes
//   captured_count    : gated beats in the current/last one-shot
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_sync_capture #(
    parameter int NUM_CHANNELS        = 4,
    parameter int DATA_PATH_WIDTH     = 2,
    parameter int DMA_BITS_PER_SAMPLE = 16,
    parameter int LINK_DELAY          = 1,
    parameter int COUNT_WIDTH         = 32,
    parameter int EXT_SYNC            = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    ad_ip_jesd204_tpl_adc_sync_capture_if.slave bus,
    input  logic [NUM_CHANNELS-1:0] ch_enable,
    input  logic                   ext_sync_arm,
    input  logic                   ext_sync_disarm,
    input  logic                   sync_in,
    input  logic                   sync_manual_req,
    input  logic                   capture_mode,
    input  logic [COUNT_WIDTH-1:0] capture_length,
    output logic                   adc_sync_status,
    output logic                   adc_rst_sync,
    output logic                   capture_active,
    output logic                   capture_done,
    output logic [COUNT_WIDTH-1:0] captured_count
);
    localparam int W  = DATA_PATH_WIDTH * DMA_BITS_PER_SAMPLE;
    localparam int DW = NUM_CHANNELS * W;

    localparam logic [1:0] ST_DISARMED  = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_CAPTURING = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    logic [LINK_DELAY-1:0] vld_p;
    logic [DW-1:0]         dat_p [LINK_DELAY];
    logic                  v_dly;
    logic [DW-1:0]         d_dly;

    logic [1:0]             state, state_nxt;
    logic [COUNT_WIDTH-1:0] count_nxt;
    logic                   done_nxt;
    logic                   sync_in_d;
    logic                   trigger;
    logic                   gate;
    logic                   beat;
    logic                   last_beat;

    // ---- delay line: in_* -> v_dly/d_dly, LINK_DELAY cycles ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            for (int k = 0; k < LINK_DELAY; k++) dat_p[k] <= '0;
        end else begin
            vld_p[0] <= bus.in_valid;
            dat_p[0] <= bus.in_data;
            for (int k = 1; k < LINK_DELAY; k++) begin
                vld_p[k] <= vld_p[k-1];
                dat_p[k] <= dat_p[k-1];
            end
        end
    end

    assign v_dly = vld_p[LINK_DELAY-1];
    assign d_dly = dat_p[LINK_DELAY-1];

    // ---- output stage: gate from registered state, mask disabled channels ----
    assign gate = (state == ST_DISARMED) || (state == ST_CAPTURING);
    assign beat = v_dly & gate;

    always_comb begin
        bus.adc_valid = '0;
        bus.adc_data  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            bus.adc_valid[i] = v_dly & ch_enable[i] & gate;
            if (ch_enable[i]) bus.adc_data[W*i +: W] = d_dly[W*i +: W];
        end
    end

    // ---- sync state machine ----
    assign trigger   = (sync_in & ~sync_in_d) | sync_manual_req;
    assign last_beat = (capture_length != '0) && (captured_count == capture_length - CNT_ONE);

    always_comb begin
        state_nxt = state;
        count_nxt = captured_count;
        done_nxt  = 1'b0;
        case (state)
            ST_DISARMED: begin
                if (ext_sync_arm && !ext_sync_disarm) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (ext_sync_disarm) begin
                    state_nxt = ST_DISARMED;
                end else if (trigger) begin
                    if (capture_mode) begin
                        state_nxt = ST_CAPTURING;
                        count_nxt = '0;
                    end else begin
                        state_nxt = ST_DISARMED;
                    end
                end
            end
            ST_CAPTURING: begin
                // The beat on the cycle of a disarm is still counted.
                if (beat) count_nxt = sat_inc(captured_count);
                if (ext_sync_disarm) begin
                    state_nxt = ST_DISARMED;
                end else if (beat && last_beat) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                if (ext_sync_disarm)   state_nxt = ST_DISARMED;
                else if (ext_sync_arm) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_DISARMED;
        endcase
        if (EXT_SYNC == 0) begin
            state_nxt = ST_DISARMED;
            count_nxt = captured_count;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_DISARMED;
            captured_count <= '0;
            capture_done   <= 1'b0;
            sync_in_d      <= 1'b0;
        end else begin
            state          <= state_nxt;
            captured_count <= count_nxt;
            capture_done   <= done_nxt;
            sync_in_d      <= sync_in;
        end
    end

    assign adc_sync_status = (state == ST_ARMED);
    assign adc_rst_sync    = adc_sync_status;
    assign capture_active  = (state == ST_CAPTURING);
endmodule

// File: doc/ad_ip_jesd204_tpl_adc_sync_capture.md
# ad_ip_jesd204_tpl_adc_sync_capture

Multi-channel, parametrised capture controller between the TPL ADC deframer/formatter and the DMA write interface. It aligns link valid with formatted data through a configurable pipeline delay, gates per-channel valid through an external-sync state machine, and adds a one-shot, length-limited capture mode with a done pulse and beat counter. Continuous streaming after a sync event is also supported.

## Interface
- NUM_CHANNELS, 4, number of converter channels
- DATA_PATH_WIDTH, 2, samples per channel per beat
- DMA_BITS_PER_SAMPLE, 16, formatted sample width
- LINK_DELAY, 1, pipeline registers on data/valid, legal 1..4
- COUNT_WIDTH, 32, width of capture_length and captured_count
- EXT_SYNC, 1, 0 = sync FSM disabled, data always streams
- clk  input  1  core clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  link beat valid from deframer path
- in_data  input  NUM_CHANNELS*DATA_PATH_WIDTH*DMA_BITS_PER_SAMPLE  formatted samples, channel i at [W*i +: W], W = DATA_PATH_WIDTH*DMA_BITS_PER_SAMPLE
- ch_enable  input  NUM_CHANNELS  per-channel enable
- ext_sync_arm  input  1  arm request, single-cycle pulse
- ext_sync_disarm  input  1  disarm request, single-cycle pulse
- sync_in  input  1  external trigger level, already synchronous to clk
- sync_manual_req  input  1  software trigger pulse
- capture_mode  input  1  0 = continuous after trigger, 1 = one-shot
- capture_length  input  COUNT_WIDTH  beats per one-shot; 0 = unlimited
- adc_valid  output  NUM_CHANNELS  per-channel valid to DMA
- adc_data  output  same as in_data  delayed data, disabled channels zeroed
- adc_sync_status  output  1  high in ARMED
- adc_rst_sync  output  1  equals adc_sync_status
- capture_active  output  1  high in CAPTURING
- capture_done  output  1  one-cycle pulse on CAPTURING -> DONE
- captured_count  output  COUNT_WIDTH  valid beats in current/last one-shot

## Operation
- States: DISARMED, ARMED, CAPTURING, DONE; reset state DISARMED.
- trigger = (sync_in & ~sync_in_d) | sync_manual_req; sync_in_d is a register with reset value 0.
- DISARMED: gate open. ext_sync_arm -> ARMED. trigger is ignored.
- ARMED: gate closed. ext_sync_disarm -> DISARMED. trigger with capture_mode=0 -> DISARMED. trigger with capture_mode=1 -> CAPTURING, and captured_count clears to 0. ext_sync_arm is ignored.
- CAPTURING: gate open. Each output beat with gated valid increments captured_count, saturating at all-ones. If capture_length != 0 and the beat is counted while captured_count == capture_length-1, the next state is DONE. ext_sync_disarm -> DISARMED; captured_count holds its value.
- DONE: gate closed; captured_count holds. ext_sync_arm -> ARMED; ext_sync_disarm -> DISARMED.
- Simultaneous arm and disarm: disarm wins in every state.
- A terminal beat coincident with disarm goes to DISARMED. No capture_done pulse is issued; the count still includes the beat.
- EXT_SYNC=0: FSM held in DISARMED, all sync inputs ignored, adc_sync_status = 0.
- Per-channel valid: adc_valid[i] = v_dly & ch_enable[i] & gate.
- Per-channel data: adc_data channel i = d_dly(i) when ch_enable[i], else 0.
- capture_length and capture_mode are sampled every cycle. Software changes them only outside CAPTURING.

## Timing
- Data path: in_valid/in_data at cycle t appears as v_dly/d_dly at t+LINK_DELAY. Data and valid stay aligned.
- gate is a function of the registered state in the output cycle.
- Trigger seen in ARMED at cycle t: state changes at t+1. The first gated beat is v_dly at t+1.
- Terminal beat at cycle t: state is DONE and capture_done = 1 at t+1. adc_valid = 0 from t+1. captured_count = capture_length from t+1.
- Arm at cycle t: adc_sync_status = 1 and adc_valid = 0 from t+1.
- Reset values:
  - all outputs 0
  - state DISARMED
  - delay line valid bits 0, data 0
  - captured_count 0
  - sync_in_d 0
- Asserting rst mid-capture returns to DISARMED immediately with no done pulse.

## Test plan
- Reset, then in_valid=1 constantly with ch_enable=4'b1011 -> after LINK_DELAY cycles adc_valid=4'b1011 every cycle, channel 2 data = 0.
- Arm, hold 5 cycles, pulse sync_manual_req with capture_mode=1 and capture_length=8, in_valid toggling 1/0 -> exactly 8 valid beats, then capture_done for one cycle, captured_count=8, adc_valid=0.
- Arm, then a sync_in rising edge with capture_mode=0 -> state DISARMED, streaming resumes. A held-high sync_in does not retrigger after re-arm until it falls and rises again.
- Arm and disarm in the same cycle in DISARMED -> stays DISARMED. In CAPTURING after 3 beats, disarm -> DISARMED, no capture_done, captured_count=3.
- capture_length=0, one-shot -> CAPTURING indefinitely over 1000 beats, count=1000. Assert rst mid-capture -> all outputs 0 next cycle.
- EXT_SYNC=0 with arm and triggers applied -> adc_valid never gated, adc_sync_status stays 0.
